// File: rtl/wshb_frame_reader_pkg.sv
// Shared types and sizing helpers for the Wishbone frame-buffer reader.
package wshb_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned DEF_HDISP = 800;
  localparam int unsigned DEF_VDISP = 480;
  localparam int unsigned NPIX      = DEF_HDISP * DEF_VDISP;
  localparam int unsigned PIX_W     = 32;
  localparam int unsigned FIFO_W    = PIX_W + 1;

  // Bits needed to index n distinct values; never less than 1.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned npix(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/wshb_frame_reader_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is always visible on rdata.
module sync_fifo
  import wshb_frame_reader_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_W,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = width_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; only pointers and count are control state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign fill  = count;

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone master streaming the frame buffer linearly into a FWFT FIFO for the display path.
module wshb_frame_reader
  import wshb_frame_reader_pkg::*;
#(
  parameter int unsigned HDISP      = DEF_HDISP,
  parameter int unsigned VDISP      = DEF_VDISP,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic [31:0] wshb_adr,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic [31:0] wshb_dat_ms,
  input  logic        wshb_ack,
  input  logic [31:0] wshb_dat_sm,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  output logic [31:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        enable
);

  localparam int unsigned PIX_COUNT = npix(HDISP, VDISP);
  localparam int unsigned IDX_W     = width_of(PIX_COUNT);
  localparam int unsigned FILL_W    = width_of(FIFO_DEPTH) + 1;
  localparam int unsigned TEN_W     = width_of(MAX_BURST + 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    pix_idx;
  logic [TEN_W-1:0]    tenure;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   free_slots;
  logic [FILL_W-1:0]   free_after;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                last_pix;
  logic                burst_last;
  logic [FIFO_W-1:0]   fifo_in;
  logic [FIFO_W-1:0]   fifo_out;

  assign push       = (state == REQ) && wshb_ack;
  assign pop        = pix_valid && pix_ready;
  assign free_slots = FILL_W'(FIFO_DEPTH) - fill;
  // Room left once the word being acked lands, counting a same-cycle pop.
  assign free_after = free_slots - FILL_W'(1) + FILL_W'(pop);
  assign last_pix   = (pix_idx == IDX_W'(PIX_COUNT - 1));
  assign burst_last = (tenure >= TEN_W'(MAX_BURST - 1));

  // Bus FSM: two free slots are required so the in-flight word always fits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && !fifo_full && (free_slots >= FILL_W'(2))) state_nxt = REQ;
      end
      REQ: begin
        if (wshb_ack) begin
          if ((free_after < FILL_W'(2)) || burst_last || !enable) state_nxt = RELEASE;
        end else if (wshb_err || wshb_rty) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pixel index and tenure count; err/rty leave the index alone so it is retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_idx <= '0;
      tenure  <= '0;
    end else begin
      if (push) begin
        pix_idx <= last_pix ? '0 : pix_idx + IDX_W'(1);
        tenure  <= tenure + TEN_W'(1);
      end
      if (state == RELEASE) tenure <= '0;
    end
  end

  assign wshb_cyc    = (state == REQ);
  assign wshb_stb    = (state == REQ);
  assign wshb_adr    = BASE_ADDR + (32'(pix_idx) << 2);
  assign wshb_we     = 1'b0;
  assign wshb_sel    = 4'hF;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign wshb_dat_ms = 32'h0;

  assign fifo_in = {(pix_idx == '0), wshb_dat_sm};

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  // Stream side: the FIFO head is presented directly; sof is masked while empty.
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_out[PIX_W-1:0];
  assign pix_sof   = fifo_out[PIX_W] && !fifo_empty;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader with an address-echo Wishbone slave and a stream model.
module tb_wshb_frame_reader;

  localparam int unsigned H     = 4;
  localparam int unsigned V     = 2;
  localparam int unsigned NP    = H * V;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MB    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [31:0] wshb_adr, wshb_dat_ms, wshb_dat_sm;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack, wshb_err, wshb_rty;
  logic [31:0] pix_data;
  logic        pix_sof, pix_valid, pix_ready, enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wshb_frame_reader #(
    .HDISP(H), .VDISP(V), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_adr(wshb_adr), .wshb_we(wshb_we),
    .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte), .wshb_dat_ms(wshb_dat_ms),
    .wshb_ack(wshb_ack), .wshb_dat_sm(wshb_dat_sm), .wshb_err(wshb_err), .wshb_rty(wshb_rty),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .enable(enable)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: echoes the address as data, optional random wait states, one-shot retry.
  logic [2:0]  wait_cnt = 3'd0;
  logic        rand_wait = 1'b0;
  logic        rty_on = 1'b0;
  logic        rty_used = 1'b0;
  logic [31:0] rty_addr = 32'h0;
  logic        rty_hit;

  assign rty_hit     = rty_on && !rty_used && wshb_stb && (wait_cnt == 3'd0) && (wshb_adr == rty_addr);
  assign wshb_ack    = wshb_cyc && wshb_stb && (wait_cnt == 3'd0) && !rty_hit;
  assign wshb_rty    = rty_hit;
  assign wshb_err    = 1'b0;
  assign wshb_dat_sm = wshb_adr;

  always @(posedge clk) begin
    if (wshb_stb) begin
      if (wait_cnt == 3'd0) begin
        wait_cnt <= rand_wait ? 3'($urandom_range(0, 5)) : 3'd0;
        if (rty_hit) rty_used <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Monitor and reference model, sampled on the falling edge.
  int          occ = 0, exp_idx = 0, aidx = 0, ten = 0;
  int          words = 0, acks = 0, tenures = 0, rty_cnt = 0;
  logic        exact_burst = 1'b0;
  logic        prev_cyc = 1'b0, stb_pend = 1'b0, hold_pend = 1'b0, rty_prev = 1'b0;
  logic [31:0] stb_adr = 32'h0;
  logic [32:0] hold_val = 33'h0;

  always @(negedge clk) begin
    if (stb_pend) begin
      check("stb_hold", wshb_stb, 1);
      check("adr_hold", wshb_adr, stb_adr);
    end
    if (hold_pend) begin
      check("valid_hold", pix_valid, 1);
      check("data_hold", {pix_sof, pix_data}, hold_val);
    end
    if (rty_prev) check("cyc_low_after_rty", wshb_cyc, 0);
    check("valid_vs_model", pix_valid, occ != 0);
    if (prev_cyc && !wshb_cyc) begin
      check("burst_le_max", ten <= MB, 1);
      if (exact_burst) check("burst_len", ten, MB);
      tenures <= tenures + 1;
    end
    if (wshb_rty) rty_cnt <= rty_cnt + 1;
    if (wshb_stb && wshb_ack) begin
      check("ack_adr", wshb_adr, BASE + 32'(4 * aidx));
      check("no_overflow", occ < DEPTH, 1);
      acks <= acks + 1;
    end
    if (pix_valid && pix_ready) begin
      check("pix_data", pix_data, BASE + 32'(4 * exp_idx));
      check("pix_sof", pix_sof, exp_idx == 0);
      words <= words + 1;
    end

    stb_pend  <= wshb_stb && !wshb_ack && !wshb_rty && !wshb_err && !rst;
    stb_adr   <= wshb_adr;
    hold_pend <= pix_valid && !pix_ready && !rst;
    hold_val  <= {pix_sof, pix_data};
    rty_prev  <= wshb_rty && !wshb_ack && !rst;
    prev_cyc  <= wshb_cyc;

    if (rst) begin
      occ     <= 0;
      exp_idx <= 0;
      aidx    <= 0;
      ten     <= 0;
    end else begin
      occ <= occ + int'(wshb_stb && wshb_ack) - int'(pix_valid && pix_ready);
      if (pix_valid && pix_ready) exp_idx <= (exp_idx == NP - 1) ? 0 : exp_idx + 1;
      if (wshb_stb && wshb_ack) aidx <= (aidx == NP - 1) ? 0 : aidx + 1;
      if (prev_cyc && !wshb_cyc) ten <= 0;
      else if (wshb_stb && wshb_ack) ten <= ten + 1;
    end
  end

  int  base_acks;
  int  w0;
  bit  found;

  initial begin
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", wshb_cyc, 0);
    check("rst_stb", wshb_stb, 0);
    check("rst_adr", wshb_adr, BASE);
    check("rst_valid", pix_valid, 0);
    check("rst_sof", pix_sof, 0);
    check("tie_we", wshb_we, 0);
    check("tie_sel", wshb_sel, 4'hF);
    check("tie_cti", wshb_cti, 0);
    check("tie_bte", wshb_bte, 0);
    check("tie_dat", wshb_dat_ms, 0);

    // Zero-wait streaming: full 64-ack tenures, frame wrap every 8 words.
    rst = 1'b0; exact_burst = 1'b1; enable = 1'b1; pix_ready = 1'b1;
    repeat (220) @(posedge clk);
    #1;
    check("t1_tenures", tenures >= 3, 1);
    check("t1_words", words >= 190, 1);

    // Stalled stream: 15 acks fill the 16-deep FIFO, then the bus stays idle.
    exact_burst = 1'b0; pix_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    base_acks = acks;
    repeat (40) @(posedge clk);
    #1;
    check("t3_acks_full", acks - base_acks, 15);
    check("t3_cyc_idle", wshb_cyc, 0);
    check("t3_valid", pix_valid, 1);
    pix_ready = 1'b1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t3_acks_one_more", acks - base_acks, 16);
    check("t3_cyc_idle2", wshb_cyc, 0);
    pix_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (wshb_cyc) found = 1'b1;
    end
    check("t3_resume", found, 1);

    // One retry at BASE+0x10: no push, no address advance, stream unbroken.
    repeat (20) @(posedge clk);
    #1;
    rty_addr = BASE + 32'h10; rty_on = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("t4_rty_count", rty_cnt, 1);
    rty_on = 1'b0;

    // Random wait states and random backpressure.
    rand_wait = 1'b1;
    w0 = words;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      pix_ready = 1'($urandom_range(0, 1));
    end
    pix_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t5_progress", words > w0 + 50, 1);

    // Reset while a strobe is waiting for its ack.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (wshb_stb && wait_cnt != 3'd0) found = 1'b1;
    end
    check("t6_find_wait", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_cyc", wshb_cyc, 0);
    check("t6_valid", pix_valid, 0);
    check("t6_adr", wshb_adr, BASE);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (wshb_stb && wshb_ack) begin
        found = 1'b1;
        check("t6_first_adr", wshb_adr, BASE);
      end
    end
    check("t6_ack_seen", found, 1);
    rand_wait = 1'b0;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
